ahb_line_arbiter: RTL and testbench
===================================

Name: ahb_line_arbiter

Overview:
- Schedules the shared AHB manager port between the instruction-fetch (IFU) and load/store (LSU) requesters inside the Wally core.
- Sequences single beats or cache-line bursts: owner selection, HTRANS/HBURST generation and beat counting.
- Grant is held until the last data phase completes.
- Sits between the IFU/LSU bus front-ends and the AHB address/control mux, configured from the cvw_t package.

Parameters:
- P, cvw_t (package default config): source of AHBW, BURST_EN, ICACHE_LINELENINBITS, DCACHE_LINELENINBITS.
- STARVE_LIMIT, 4: consecutive LSU grants allowed while IFU waits before IFU is forced to win.
- Derived, not overridable:
  - IBEATS = P.ICACHE_LINELENINBITS/P.AHBW
  - DBEATS = P.DCACHE_LINELENINBITS/P.AHBW
  - CW = $clog2(max(IBEATS,DBEATS)+1)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- IFUReq  in  1  IFU requests bus
- IFULine  in  1  IFU request is a full line (else single beat)
- LSUReq  in  1  LSU requests bus
- LSULine  in  1  LSU request is a full line (else single beat)
- HREADY  in  1  AHB transfer ready
- HRESP  in  1  AHB error response
- IFUGrant  out  1  IFU owns bus
- LSUGrant  out  1  LSU owns bus
- HTRANS  out  2  AHB transfer type
- HBURST  out  3  AHB burst type
- BeatCount  out  CW  index of current address-phase beat
- IFUDone  out  1  one-cycle pulse: IFU transaction finished
- LSUDone  out  1  one-cycle pulse: LSU transaction finished
- BusErr  out  1  one-cycle pulse alongside Done when HRESP aborted the transaction

Behaviour:
- Reset (HRESETn=0, asynchronous, effective at any time including mid-burst):
  - state=IDLE; all outputs 0; starvation counter 0.
  - No Done pulse for an aborted transaction.
- States: IDLE, ADDR, BURST, LAST.
- IDLE:
  - Owner chosen if any Req: LSU wins, unless IFUReq=1 and starve count == STARVE_LIMIT, in which case IFU wins.
  - Grant, Line flag and beat total (Line ? IBEATS/DBEATS : 1) are registered; next state ADDR.
  - Latency: Req sampled in cycle N gives Grant=1 and HTRANS=NONSEQ in cycle N+1.
- Starve counter:
  - Increments on each LSU grant while IFUReq=1; saturates at STARVE_LIMIT.
  - Clears on IFU grant, or when IFUReq=0 in IDLE.
- ADDR:
  - HTRANS=NONSEQ (2'b10), BeatCount=0.
  - On HREADY: if total==1 go LAST; else go BURST with BeatCount=1.
- BURST:
  - HTRANS=SEQ (2'b11) when P.BURST_EN; otherwise NONSEQ every beat.
  - BeatCount increments on each HREADY.
  - When the beat with BeatCount==total-1 is accepted, go LAST.
- LAST:
  - HTRANS=IDLE (2'b00).
  - On HREADY: pulse owner's Done, drop Grant, go IDLE.
  - Back-to-back requests therefore have one IDLE cycle between them.
- HBURST:
  - Held constant for the whole transaction.
  - When P.BURST_EN and Line: total 4 -> INCR4 (3'b011), 8 -> INCR8 (3'b101), 16 -> INCR16 (3'b111).
  - Otherwise SINGLE (3'b000), including any other total.
- HREADY=0: state, BeatCount and HTRANS hold (the AHB stall rule).
- Requester behaviour after grant:
  - Req deassertion after grant is ignored; the transaction always completes.
  - Req must stay high until Done.
- HRESP=1 with HREADY=0 (first error cycle) in ADDR, BURST or LAST:
  - Force HTRANS=IDLE next cycle and go to LAST.
  - The following HREADY completes with Done=1 and BusErr=1.
- Simultaneous IFUReq and LSUReq in IDLE: resolved purely by the starvation rule above; exactly one Grant.
- Invariant: IFUGrant & LSUGrant is never 1.

Decomposition:
- Add to the shared cvw package:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_BURST, ARB_LAST} arbstate_t
  - localparams HTRANS_IDLE / HTRANS_NONSEQ / HTRANS_SEQ
  - HBURST encodings SINGLE / INCR4 / INCR8 / INCR16
- One sub-module, ahb_burst_type: combinational map from (total beats, Line, BURST_EN) to HBURST, reusable by other AHB managers.
- Everything else stays in one FSM module.

Test Plan:
1. Reset with LSUReq=1 held, then release HRESETn:
   - Outputs 0 during reset.
   - First cycle after release: LSUGrant=0; next cycle LSUGrant=1, HTRANS=2'b10.
2. AHBW=64, DCACHE_LINELENINBITS=512, BURST_EN=1, LSULine=1, HREADY always 1:
   - HBURST=3'b101.
   - HTRANS sequence NONSEQ, SEQ×7, IDLE.
   - BeatCount 0..7.
   - LSUDone pulses exactly once, 10 cycles after request.
3. Same as test 2 with HREADY=0 for 3 cycles at beat 3:
   - BeatCount stays 3 and HTRANS stays SEQ throughout the stall.
   - Done is delayed by exactly 3 cycles.
4. IFUReq and LSUReq both held high, all single beats, STARVE_LIMIT=4:
   - Grant order LSU, LSU, LSU, LSU, IFU, then repeats.
5. HRESP=1 with HREADY=0 at beat 2 of an IFU line burst:
   - Next cycle HTRANS=IDLE.
   - On the following HREADY: IFUDone=1 and BusErr=1; next state IDLE.
6. HRESETn asserted mid-burst at beat 5:
   - All outputs immediately 0; no Done.
   - After release, a new IFUReq gets a NONSEQ with BeatCount=0.

Source files
------------

// File: rtl/ahb_line_arbiter_pkg.sv
// Shared core configuration and AHB manager encodings used by the
// line arbiter and any other AHB manager in the core.
package ahb_line_arbiter_pkg;

    // Subset of the core configuration that the AHB managers depend on.
    typedef struct packed {
        int unsigned AHBW;
        logic        BURST_EN;
        int unsigned ICACHE_LINELENINBITS;
        int unsigned DCACHE_LINELENINBITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{
        AHBW:                 32'd64,
        BURST_EN:             1'b1,
        ICACHE_LINELENINBITS: 32'd512,
        DCACHE_LINELENINBITS: 32'd512
    };

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ADDR  = 2'b01,
        ARB_BURST = 2'b10,
        ARB_LAST  = 2'b11
    } arbstate_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Larger of two elaboration-time counts, used to size beat counters.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ahb_line_arbiter_burst_type.sv
// Maps a transaction's beat total to the AHB HBURST encoding. Only the
// fixed-length incrementing bursts AHB defines are used; anything else
// is issued as independent SINGLE transfers.
module ahb_burst_type
    import ahb_line_arbiter_pkg::*;
#(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] total_i,
    input  logic          line_i,
    input  logic          burst_en_i,
    output logic [2:0]    hburst_o
);

    // Select the burst encoding for the beat total of a line transfer.
    always_comb begin
        hburst_o = HBURST_SINGLE;
        if (burst_en_i && line_i) begin
            case (32'(total_i))
                32'd4:   hburst_o = HBURST_INCR4;
                32'd8:   hburst_o = HBURST_INCR8;
                32'd16:  hburst_o = HBURST_INCR16;
                default: hburst_o = HBURST_SINGLE;
            endcase
        end else begin
            hburst_o = HBURST_SINGLE;
        end
    end

endmodule

// File: rtl/ahb_line_arbiter.sv
// Arbitrates the shared AHB manager port between IFU and LSU. LSU has
// priority, but a waiting IFU is forced through after STARVE_LIMIT
// consecutive LSU grants. The owner keeps the bus until the final data
// phase of its single beat or cache-line burst completes.
module ahb_line_arbiter
    import ahb_line_arbiter_pkg::*;
#(
    parameter cvw_t        P            = CVW_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned IBEATS = P.ICACHE_LINELENINBITS / P.AHBW,
    localparam int unsigned DBEATS = P.DCACHE_LINELENINBITS / P.AHBW,
    localparam int unsigned CW     = $clog2(max_u(IBEATS, DBEATS) + 1)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          IFUReq,
    input  logic          IFULine,
    input  logic          LSUReq,
    input  logic          LSULine,
    input  logic          HREADY,
    input  logic          HRESP,
    output logic          IFUGrant,
    output logic          LSUGrant,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HBURST,
    output logic [CW-1:0] BeatCount,
    output logic          IFUDone,
    output logic          LSUDone,
    output logic          BusErr
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arbstate_t     state_q;
    logic          ifu_grant_q;
    logic          lsu_grant_q;
    logic [1:0]    htrans_q;
    logic [2:0]    hburst_q;
    logic [CW-1:0] beat_q;
    logic [CW-1:0] total_q;
    logic [SW-1:0] starve_q;
    logic          err_q;
    logic          ifu_done_q;
    logic          lsu_done_q;
    logic          bus_err_q;

    logic          ifu_wins_d;
    logic          line_d;
    logic [CW-1:0] total_d;
    logic [2:0]    hburst_d;

    // Owner choice and beat total for a request seen in IDLE.
    always_comb begin
        ifu_wins_d = IFUReq & (~LSUReq | (starve_q == SW'(STARVE_LIMIT)));
        line_d     = 1'b0;
        total_d    = CW'(1);
        if (ifu_wins_d) begin
            line_d  = IFULine;
            total_d = IFULine ? CW'(IBEATS) : CW'(1);
        end else begin
            line_d  = LSULine;
            total_d = LSULine ? CW'(DBEATS) : CW'(1);
        end
    end

    ahb_burst_type #(
        .CW (CW)
    ) u_burst_type (
        .total_i    (total_d),
        .line_i     (line_d),
        .burst_en_i (P.BURST_EN),
        .hburst_o   (hburst_d)
    );

    // Transaction sequencer: grant, address-phase control, beat count and
    // completion pulses, all registered.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ARB_IDLE;
            ifu_grant_q <= 1'b0;
            lsu_grant_q <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hburst_q    <= HBURST_SINGLE;
            beat_q      <= '0;
            total_q     <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            ifu_done_q  <= 1'b0;
            lsu_done_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            ifu_done_q <= 1'b0;
            lsu_done_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (IFUReq || LSUReq) begin
                        state_q     <= ARB_ADDR;
                        ifu_grant_q <= ifu_wins_d;
                        lsu_grant_q <= ~ifu_wins_d;
                        htrans_q    <= HTRANS_NONSEQ;
                        hburst_q    <= hburst_d;
                        beat_q      <= '0;
                        total_q     <= total_d;
                        err_q       <= 1'b0;
                        if (ifu_wins_d || !IFUReq) begin
                            starve_q <= '0;
                        end else if (starve_q != SW'(STARVE_LIMIT)) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end else begin
                        starve_q <= '0;
                    end
                end
                ARB_ADDR, ARB_BURST: begin
                    // First error cycle: stop issuing beats and wait for the
                    // second error cycle to close the transaction.
                    if (HRESP && !HREADY) begin
                        state_q  <= ARB_LAST;
                        htrans_q <= HTRANS_IDLE;
                        err_q    <= 1'b1;
                    end else if (HREADY) begin
                        if (state_q == ARB_ADDR && total_q == CW'(1)) begin
                            state_q  <= ARB_LAST;
                            htrans_q <= HTRANS_IDLE;
                        end else if (state_q == ARB_ADDR) begin
                            state_q  <= ARB_BURST;
                            beat_q   <= CW'(1);
                            htrans_q <= P.BURST_EN ? HTRANS_SEQ : HTRANS_NONSEQ;
                        end else if (beat_q == total_q - CW'(1)) begin
                            state_q  <= ARB_LAST;
                            htrans_q <= HTRANS_IDLE;
                        end else begin
                            beat_q <= beat_q + CW'(1);
                        end
                    end
                end
                ARB_LAST: begin
                    if (HRESP && !HREADY) begin
                        err_q <= 1'b1;
                    end else if (HREADY) begin
                        state_q     <= ARB_IDLE;
                        ifu_done_q  <= ifu_grant_q;
                        lsu_done_q  <= lsu_grant_q;
                        bus_err_q   <= err_q;
                        ifu_grant_q <= 1'b0;
                        lsu_grant_q <= 1'b0;
                        hburst_q    <= HBURST_SINGLE;
                        beat_q      <= '0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    ifu_grant_q <= 1'b0;
                    lsu_grant_q <= 1'b0;
                    htrans_q    <= HTRANS_IDLE;
                    hburst_q    <= HBURST_SINGLE;
                    beat_q      <= '0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign IFUGrant  = ifu_grant_q;
    assign LSUGrant  = lsu_grant_q;
    assign HTRANS    = htrans_q;
    assign HBURST    = hburst_q;
    assign BeatCount = beat_q;
    assign IFUDone   = ifu_done_q;
    assign LSUDone   = lsu_done_q;
    assign BusErr    = bus_err_q;

endmodule

// File: tb/tb_ahb_line_arbiter.sv
// Directed bench for the IFU/LSU AHB line arbiter (default config:
// 64-bit bus, 512-bit lines -> 8-beat INCR8 bursts, STARVE_LIMIT=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ahb_line_arbiter;

    logic       HCLK;
    logic       HRESETn;
    logic       IFUReq, IFULine, LSUReq, LSULine, HREADY, HRESP;
    logic       IFUGrant, LSUGrant, IFUDone, LSUDone, BusErr;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [3:0] BeatCount;

    int n_checks = 0;
    int n_errors = 0;

    ahb_line_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .IFUReq    (IFUReq),
        .IFULine   (IFULine),
        .LSUReq    (LSUReq),
        .LSULine   (LSULine),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .IFUGrant  (IFUGrant),
        .LSUGrant  (LSUGrant),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .BeatCount (BeatCount),
        .IFUDone   (IFUDone),
        .LSUDone   (LSUDone),
        .BusErr    (BusErr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 8-beat LSU line burst; d>0 stalls HREADY for d cycles at beat 3.
    task automatic run_lsu_line(input int d);
        int exp_beat;
        LSUReq  = 1'b1;
        LSULine = 1'b1;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        for (int k = 1; k <= 11 + d; k++) begin
            @(negedge HCLK);
            check_eq($sformatf("line d=%0d grant k=%0d", d, k), 32'(LSUGrant), (k <= 9 + d) ? 32'd1 : 32'd0);
            check_eq($sformatf("line d=%0d done k=%0d", d, k), 32'(LSUDone), (k == 10 + d) ? 32'd1 : 32'd0);
            if (k == 1) begin
                check_eq($sformatf("line d=%0d htrans k=%0d", d, k), 32'(HTRANS), 32'd2);
                check_eq($sformatf("line d=%0d hburst", d), 32'(HBURST), 32'd5);
            end else if (k <= 8 + d) begin
                check_eq($sformatf("line d=%0d htrans k=%0d", d, k), 32'(HTRANS), 32'd3);
            end else begin
                check_eq($sformatf("line d=%0d htrans k=%0d", d, k), 32'(HTRANS), 32'd0);
            end
            if (k <= 8 + d) begin
                exp_beat = (k <= 4) ? k - 1 : ((k <= 4 + d) ? 3 : k - 1 - d);
                check_eq($sformatf("line d=%0d beat k=%0d", d, k), 32'(BeatCount), 32'(exp_beat));
            end
            if (k == 10 + d) LSUReq = 1'b0;
            HREADY = (d != 0 && k >= 4 && k <= 3 + d) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset with LSUReq held, then release.
        HRESETn = 1'b0;
        IFUReq  = 1'b0; IFULine = 1'b0;
        LSUReq  = 1'b1; LSULine = 1'b0;
        HREADY  = 1'b1; HRESP   = 1'b0;
        repeat (3) @(negedge HCLK);
        check_eq("rst lsugrant", 32'(LSUGrant), 32'd0);
        check_eq("rst ifugrant", 32'(IFUGrant), 32'd0);
        check_eq("rst htrans", 32'(HTRANS), 32'd0);
        check_eq("rst hburst", 32'(HBURST), 32'd0);
        check_eq("rst beat", 32'(BeatCount), 32'd0);
        check_eq("rst done", 32'({IFUDone, LSUDone, BusErr}), 32'd0);
        HRESETn = 1'b1;
        #1;
        check_eq("rel first lsugrant", 32'(LSUGrant), 32'd0);
        @(negedge HCLK);
        check_eq("rel lsugrant", 32'(LSUGrant), 32'd1);
        check_eq("rel htrans", 32'(HTRANS), 32'd2);
        check_eq("single hburst", 32'(HBURST), 32'd0);
        check_eq("single beat", 32'(BeatCount), 32'd0);
        @(negedge HCLK);
        check_eq("single last htrans", 32'(HTRANS), 32'd0);
        check_eq("single last grant", 32'(LSUGrant), 32'd1);
        @(negedge HCLK);
        check_eq("single done", 32'(LSUDone), 32'd1);
        check_eq("single grant drop", 32'(LSUGrant), 32'd0);
        check_eq("single no err", 32'(BusErr), 32'd0);
        LSUReq = 1'b0;
        @(negedge HCLK);
        check_eq("single done once", 32'(LSUDone), 32'd0);

        // Tests 2 and 3: full line burst, then with a 3-cycle stall at beat 3.
        run_lsu_line(0);
        @(negedge HCLK);
        run_lsu_line(3);
        @(negedge HCLK);

        // Test 4: both requesting single beats -> L L L L I repeating.
        IFUReq = 1'b1; IFULine = 1'b0;
        LSUReq = 1'b1; LSULine = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge HCLK);
            check_eq($sformatf("starve excl k=%0d", k), 32'(IFUGrant & LSUGrant), 32'd0);
            if (k % 3 == 1) begin
                check_eq($sformatf("starve lsu j=%0d", (k - 1) / 3), 32'(LSUGrant), (((k - 1) / 3) % 5 != 4) ? 32'd1 : 32'd0);
                check_eq($sformatf("starve ifu j=%0d", (k - 1) / 3), 32'(IFUGrant), (((k - 1) / 3) % 5 == 4) ? 32'd1 : 32'd0);
            end
            if (k == 30) begin
                check_eq("starve final ifudone", 32'(IFUDone), 32'd1);
                IFUReq = 1'b0;
                LSUReq = 1'b0;
            end
        end
        @(negedge HCLK);

        // Test 5: error response at beat 2 of an IFU line burst.
        IFUReq = 1'b1; IFULine = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        check_eq("err ifugrant", 32'(IFUGrant), 32'd1);
        check_eq("err htrans0", 32'(HTRANS), 32'd2);
        check_eq("err hburst", 32'(HBURST), 32'd5);
        @(negedge HCLK);
        @(negedge HCLK);
        check_eq("err beat2", 32'(BeatCount), 32'd2);
        check_eq("err htrans2", 32'(HTRANS), 32'd3);
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge HCLK);
        check_eq("err htrans idle", 32'(HTRANS), 32'd0);
        check_eq("err grant held", 32'(IFUGrant), 32'd1);
        check_eq("err no early done", 32'(IFUDone), 32'd0);
        HREADY = 1'b1;
        @(negedge HCLK);
        check_eq("err ifudone", 32'(IFUDone), 32'd1);
        check_eq("err buserr", 32'(BusErr), 32'd1);
        check_eq("err grant drop", 32'(IFUGrant), 32'd0);
        IFUReq = 1'b0; HRESP = 1'b0;
        @(negedge HCLK);
        check_eq("err buserr pulse", 32'(BusErr), 32'd0);
        check_eq("err idle htrans", 32'(HTRANS), 32'd0);

        // Test 6: asynchronous reset in the middle of a burst.
        LSUReq = 1'b1; LSULine = 1'b1; HREADY = 1'b1;
        repeat (6) @(negedge HCLK);
        check_eq("midrst beat5", 32'(BeatCount), 32'd5);
        HRESETn = 1'b0;
        #1;
        check_eq("midrst grant", 32'({IFUGrant, LSUGrant}), 32'd0);
        check_eq("midrst htrans", 32'(HTRANS), 32'd0);
        check_eq("midrst beat", 32'(BeatCount), 32'd0);
        check_eq("midrst hburst", 32'(HBURST), 32'd0);
        LSUReq = 1'b0;
        @(negedge HCLK);
        check_eq("midrst no done", 32'({IFUDone, LSUDone, BusErr}), 32'd0);
        HRESETn = 1'b1;
        IFUReq = 1'b1; IFULine = 1'b0;
        @(negedge HCLK);
        check_eq("post rst ifugrant", 32'(IFUGrant), 32'd1);
        check_eq("post rst htrans", 32'(HTRANS), 32'd2);
        check_eq("post rst beat", 32'(BeatCount), 32'd0);
        check_eq("post rst lsudone", 32'(LSUDone), 32'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        check_eq("post rst ifudone", 32'(IFUDone), 32'd1);
        check_eq("post rst lsudone2", 32'(LSUDone), 32'd0);
        IFUReq = 1'b0;
        @(negedge HCLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
